// File: rtl/data_memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_arbiter
//  Description : Shares the single-port data memory between the pipeline MEM
//                stage (priority owner) and an auxiliary requester. A
//                starvation counter forces an aux grant after STARVE_LIMIT
//                denied cycles, stalling the pipeline for that cycle. Aux read
//                data is returned registered with a one-cycle valid pulse.
//                Optional macro AUX_BURST_EN lets a forced aux episode retain
//                the port for up to BURST_LEN consecutive grants.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_memory_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 3,
    parameter int BURST_LEN    = 4
) (
    input  logic                  clock,
    input  logic                  resetMachine,
    // pipeline MEM stage
    input  logic                  pipeRead,
    input  logic                  pipeWrite,
    input  logic [ADDR_WIDTH-1:0] pipeAddress,
    input  logic [DATA_WIDTH-1:0] pipeWriteData,
    output logic [DATA_WIDTH-1:0] pipeReadData,
    output logic                  pipeStall,
    // auxiliary requester
    input  logic                  auxRequest,
    input  logic                  auxWrite,
    input  logic                  auxBurst,
    input  logic [ADDR_WIDTH-1:0] auxAddress,
    input  logic [DATA_WIDTH-1:0] auxWriteData,
    output logic                  auxGrant,
    output logic [DATA_WIDTH-1:0] auxReadData,
    output logic                  auxReadValid,
    // memory port
    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic                  memEnableRead,
    output logic                  memEnableWrite,
    output logic [DATA_WIDTH-1:0] memDataIn,
    input  logic [DATA_WIDTH-1:0] memDataOut,
    // statistics
    output logic [31:0]           stallCycles
);

    localparam int c_WAIT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [c_WAIT_W-1:0] c_STARVE_LIMIT = c_WAIT_W'(STARVE_LIMIT);

    typedef enum logic [0:0] {
        PIPE_PRIORITY = 1'b0,
        AUX_FORCED    = 1'b1
    } state_t;

    state_t                r_state;
    logic [c_WAIT_W-1:0]   r_waitCount;
    logic [DATA_WIDTH-1:0] r_auxReadData;
    logic                  r_auxReadValid;
    logic [31:0]           r_stallCycles;

    logic                  w_pipeActive;
    logic                  w_auxOwner;
    logic                  w_pipeStall;
    logic [c_WAIT_W-1:0]   w_waitNext;

    assign w_pipeActive = pipeRead | pipeWrite;
    // Aux owns the port when forced, or opportunistically when the pipe is idle.
    assign w_auxOwner   = auxRequest & ((r_state == AUX_FORCED) | ~w_pipeActive);
    assign w_pipeStall  = (r_state == AUX_FORCED) & auxRequest & w_pipeActive;
    assign w_waitNext   = r_waitCount + 1'b1;

    // Memory port steering from the current owner; idle port is driven to zero.
    always_comb begin
        memAddress     = '0;
        memDataIn      = '0;
        memEnableRead  = 1'b0;
        memEnableWrite = 1'b0;
        pipeReadData   = '0;
        if (w_auxOwner) begin
            memAddress     = auxAddress;
            memDataIn      = auxWriteData;
            memEnableRead  = ~auxWrite;
            memEnableWrite = auxWrite;
        end else begin
            pipeReadData = memDataOut;
            if (w_pipeActive) begin
                memAddress     = pipeAddress;
                memDataIn      = pipeWriteData;
                memEnableRead  = pipeRead;
                memEnableWrite = pipeWrite;
            end
        end
    end

`ifdef AUX_BURST_EN
    localparam int c_BURST_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [c_BURST_W-1:0] c_BURST_LAST = c_BURST_W'(BURST_LEN - 1);

    logic [c_BURST_W-1:0] r_burstCount;

    // Arbitration FSM with starvation counter and burst retention.
    always_ff @(posedge clock or negedge resetMachine) begin
        if (!resetMachine) begin
            r_state      <= PIPE_PRIORITY;
            r_waitCount  <= '0;
            r_burstCount <= '0;
        end else begin
            case (r_state)
                PIPE_PRIORITY: begin
                    r_burstCount <= '0;
                    if (auxRequest && !w_auxOwner) begin
                        if (w_waitNext == c_STARVE_LIMIT) begin
                            r_state     <= AUX_FORCED;
                            r_waitCount <= '0;
                        end else begin
                            r_waitCount <= w_waitNext;
                        end
                    end else begin
                        r_waitCount <= '0;
                    end
                end
                AUX_FORCED: begin
                    r_waitCount <= '0;
                    // Stay forced only while the requester asks to keep the burst.
                    if (auxRequest && auxBurst && (r_burstCount < c_BURST_LAST)) begin
                        r_burstCount <= r_burstCount + 1'b1;
                    end else begin
                        r_state      <= PIPE_PRIORITY;
                        r_burstCount <= '0;
                    end
                end
                default: begin
                    r_state      <= PIPE_PRIORITY;
                    r_waitCount  <= '0;
                    r_burstCount <= '0;
                end
            endcase
        end
    end
`else
    logic w_unusedBurst;
    assign w_unusedBurst = auxBurst;

    // Arbitration FSM with starvation counter; one forced grant per episode.
    always_ff @(posedge clock or negedge resetMachine) begin
        if (!resetMachine) begin
            r_state     <= PIPE_PRIORITY;
            r_waitCount <= '0;
        end else begin
            case (r_state)
                PIPE_PRIORITY: begin
                    if (auxRequest && !w_auxOwner) begin
                        if (w_waitNext == c_STARVE_LIMIT) begin
                            r_state     <= AUX_FORCED;
                            r_waitCount <= '0;
                        end else begin
                            r_waitCount <= w_waitNext;
                        end
                    end else begin
                        r_waitCount <= '0;
                    end
                end
                AUX_FORCED: begin
                    // Leave after the grant, or immediately if the request vanished.
                    r_state     <= PIPE_PRIORITY;
                    r_waitCount <= '0;
                end
                default: begin
                    r_state     <= PIPE_PRIORITY;
                    r_waitCount <= '0;
                end
            endcase
        end
    end
`endif

    // Capture aux read data on the grant edge and raise a one-cycle valid.
    always_ff @(posedge clock or negedge resetMachine) begin
        if (!resetMachine) begin
            r_auxReadData  <= '0;
            r_auxReadValid <= 1'b0;
        end else begin
            r_auxReadValid <= w_auxOwner & ~auxWrite;
            if (w_auxOwner && !auxWrite) begin
                r_auxReadData <= memDataOut;
            end
        end
    end

    // Saturating count of stalled pipeline cycles.
    always_ff @(posedge clock or negedge resetMachine) begin
        if (!resetMachine) begin
            r_stallCycles <= '0;
        end else if (w_pipeStall && (r_stallCycles != 32'hFFFF_FFFF)) begin
            r_stallCycles <= r_stallCycles + 32'd1;
        end
    end

    assign auxGrant     = w_auxOwner;
    assign pipeStall    = w_pipeStall;
    assign auxReadData  = r_auxReadData;
    assign auxReadValid = r_auxReadValid;
    assign stallCycles  = r_stallCycles;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_memory_arbiter
//  Description : Directed self-checking bench for data_memory_arbiter with a
//                combinational-read word memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_arbiter;

    logic        clock = 1'b0;
    logic        resetMachine;
    logic        pipeRead, pipeWrite;
    logic [31:0] pipeAddress, pipeWriteData, pipeReadData;
    logic        pipeStall;
    logic        auxRequest, auxWrite, auxBurst;
    logic [31:0] auxAddress, auxWriteData, auxReadData;
    logic        auxGrant, auxReadValid;
    logic [31:0] memAddress, memDataIn, memDataOut;
    logic        memEnableRead, memEnableWrite;
    logic [31:0] stallCycles;

    logic [31:0] mem [0:255];
    logic        memClear;
    int          total = 0;
    int          bad   = 0;
    int          expStall = 0;

    always #5 clock = ~clock;

    data_memory_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .STARVE_LIMIT(3), .BURST_LEN(4)
    ) dut (
        .clock(clock), .resetMachine(resetMachine),
        .pipeRead(pipeRead), .pipeWrite(pipeWrite), .pipeAddress(pipeAddress),
        .pipeWriteData(pipeWriteData), .pipeReadData(pipeReadData), .pipeStall(pipeStall),
        .auxRequest(auxRequest), .auxWrite(auxWrite), .auxBurst(auxBurst),
        .auxAddress(auxAddress), .auxWriteData(auxWriteData), .auxGrant(auxGrant),
        .auxReadData(auxReadData), .auxReadValid(auxReadValid),
        .memAddress(memAddress), .memEnableRead(memEnableRead), .memEnableWrite(memEnableWrite),
        .memDataIn(memDataIn), .memDataOut(memDataOut), .stallCycles(stallCycles)
    );

    // Word-addressed memory model: combinational read, write at rising edge.
    assign memDataOut = mem[memAddress[9:2]];
    always @(posedge clock) begin
        if (memClear) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
        end else if (memEnableWrite) begin
            mem[memAddress[9:2]] <= memDataIn;
        end
    end

    task automatic nextCycle;
        @(negedge clock);
    endtask

    task automatic idleInputs;
        pipeRead = 0; pipeWrite = 0; pipeAddress = 0; pipeWriteData = 0;
        auxRequest = 0; auxWrite = 0; auxBurst = 0; auxAddress = 0; auxWriteData = 0;
    endtask

    task automatic test_reset;
        resetMachine = 0; memClear = 1; idleInputs();
        pipeRead = 1; pipeAddress = 32'h100;
        repeat (3) nextCycle();
        #1;
        total++; if (stallCycles !== 32'd0) begin bad++; $display("FAIL reset_stallCycles got=%h exp=0", stallCycles); end
        total++; if (auxReadValid !== 1'b0) begin bad++; $display("FAIL reset_auxReadValid got=%b exp=0", auxReadValid); end
        total++; if (auxReadData !== 32'd0) begin bad++; $display("FAIL reset_auxReadData got=%h exp=0", auxReadData); end
        total++; if (pipeStall !== 1'b0) begin bad++; $display("FAIL reset_pipeStall got=%b exp=0", pipeStall); end
        total++; if (auxGrant !== 1'b0) begin bad++; $display("FAIL reset_auxGrant got=%b exp=0", auxGrant); end
        nextCycle();
        memClear = 0; idleInputs(); resetMachine = 1;
    endtask

    task automatic test_aux_idle;
        nextCycle();
        auxRequest = 1; auxWrite = 1; auxAddress = 32'h40; auxWriteData = 32'hDEADBEEF;
        #1;
        total++; if (auxGrant !== 1'b1) begin bad++; $display("FAIL idle_wr_grant got=%b exp=1", auxGrant); end
        total++; if (pipeStall !== 1'b0) begin bad++; $display("FAIL idle_wr_stall got=%b exp=0", pipeStall); end
        total++; if (memEnableWrite !== 1'b1 || memAddress !== 32'h40) begin bad++; $display("FAIL idle_wr_port got we=%b a=%h exp we=1 a=40", memEnableWrite, memAddress); end
        nextCycle();
        auxWrite = 0;
        #1;
        total++; if (auxGrant !== 1'b1) begin bad++; $display("FAIL idle_rd_grant got=%b exp=1", auxGrant); end
        total++; if (memEnableRead !== 1'b1 || pipeStall !== 1'b0) begin bad++; $display("FAIL idle_rd_port got re=%b st=%b exp re=1 st=0", memEnableRead, pipeStall); end
        total++; if (auxReadValid !== 1'b0) begin bad++; $display("FAIL idle_rd_early_valid got=%b exp=0", auxReadValid); end
        nextCycle();
        auxRequest = 0;
        #1;
        total++; if (auxReadValid !== 1'b1 || auxReadData !== 32'hDEADBEEF) begin bad++; $display("FAIL idle_rd_data got v=%b d=%h exp v=1 d=deadbeef", auxReadValid, auxReadData); end
        nextCycle(); #1;
        total++; if (auxReadValid !== 1'b0) begin bad++; $display("FAIL idle_rd_pulse got=%b exp=0", auxReadValid); end
        total++; if (stallCycles !== 32'd0) begin bad++; $display("FAIL idle_stallCycles got=%0d exp=0", stallCycles); end
    endtask

    task automatic test_starvation;
        nextCycle();
        pipeRead = 1; pipeAddress = 32'h100;
        auxRequest = 1; auxWrite = 0; auxAddress = 32'h40;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (auxGrant !== 1'b0 || pipeStall !== 1'b0) begin bad++; $display("FAIL starve_deny c=%0d got g=%b st=%b exp g=0 st=0", c, auxGrant, pipeStall); end
            nextCycle();
        end
        #1;
        total++; if (auxGrant !== 1'b1 || pipeStall !== 1'b1) begin bad++; $display("FAIL starve_grant got g=%b st=%b exp g=1 st=1", auxGrant, pipeStall); end
        total++; if (memEnableRead !== 1'b1 || memAddress !== 32'h40) begin bad++; $display("FAIL starve_port got re=%b a=%h exp re=1 a=40", memEnableRead, memAddress); end
        expStall++;
        nextCycle();
        auxRequest = 0;
        #1;
        total++; if (pipeStall !== 1'b0 || auxGrant !== 1'b0) begin bad++; $display("FAIL starve_after got st=%b g=%b exp 0 0", pipeStall, auxGrant); end
        total++; if (auxReadValid !== 1'b1 || auxReadData !== 32'hDEADBEEF) begin bad++; $display("FAIL starve_rdata got v=%b d=%h exp v=1 d=deadbeef", auxReadValid, auxReadData); end
        total++; if (stallCycles !== 32'(expStall)) begin bad++; $display("FAIL starve_stallCycles got=%0d exp=%0d", stallCycles, expStall); end
        nextCycle(); idleInputs();
    endtask

    task automatic test_collision;
        nextCycle();
        pipeRead = 1; pipeAddress = 32'h100;
        auxRequest = 1; auxWrite = 0; auxAddress = 32'h40;
        repeat (3) nextCycle();
        pipeRead = 0; pipeWrite = 1; pipeAddress = 32'h80; pipeWriteData = 32'h12345678;
        #1;
        total++; if (auxGrant !== 1'b1 || pipeStall !== 1'b1 || memEnableWrite !== 1'b0) begin bad++; $display("FAIL coll_grant got g=%b st=%b we=%b exp 1 1 0", auxGrant, pipeStall, memEnableWrite); end
        expStall++;
        nextCycle();
        auxRequest = 0;
        #1;
        total++; if (mem[32] !== 32'd0) begin bad++; $display("FAIL coll_no_write got=%h exp=0", mem[32]); end
        total++; if (memEnableWrite !== 1'b1 || memAddress !== 32'h80 || pipeStall !== 1'b0) begin bad++; $display("FAIL coll_replay got we=%b a=%h st=%b exp 1 80 0", memEnableWrite, memAddress, pipeStall); end
        nextCycle();
        pipeWrite = 0; pipeRead = 1; pipeAddress = 32'h80;
        #1;
        total++; if (pipeReadData !== 32'h12345678) begin bad++; $display("FAIL coll_load got=%h exp=12345678", pipeReadData); end
        total++; if (stallCycles !== 32'(expStall)) begin bad++; $display("FAIL coll_stallCycles got=%0d exp=%0d", stallCycles, expStall); end
        nextCycle(); idleInputs();
    endtask

    task automatic test_drop;
        nextCycle();
        pipeRead = 1; pipeAddress = 32'h100;
        auxRequest = 1; auxWrite = 0; auxAddress = 32'h40;
        repeat (3) nextCycle();
        auxRequest = 0;
        #1;
        total++; if (auxGrant !== 1'b0 || pipeStall !== 1'b0) begin bad++; $display("FAIL drop_forced got g=%b st=%b exp 0 0", auxGrant, pipeStall); end
        nextCycle();
        auxRequest = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            total++; if (auxGrant !== 1'b0) begin bad++; $display("FAIL drop_restart c=%0d got g=%b exp 0", c, auxGrant); end
            nextCycle();
        end
        #1;
        total++; if (auxGrant !== 1'b1 || pipeStall !== 1'b1) begin bad++; $display("FAIL drop_regrant got g=%b st=%b exp 1 1", auxGrant, pipeStall); end
        expStall++;
        nextCycle(); idleInputs();
    endtask

    task automatic test_burst;
        int grants;
        int expGrants;
`ifdef AUX_BURST_EN
        expGrants = 4;
`else
        expGrants = 1;
`endif
        grants = 0;
        nextCycle();
        pipeRead = 1; pipeAddress = 32'h100;
        auxRequest = 1; auxBurst = 1; auxWrite = 0; auxAddress = 32'h40;
        repeat (3) nextCycle();
        for (int c = 0; c < 4; c++) begin
            #1;
            if (auxGrant === 1'b1) begin
                grants++;
                total++; if (pipeStall !== 1'b1) begin bad++; $display("FAIL burst_stall c=%0d got=%b exp=1", c, pipeStall); end
            end
            nextCycle();
        end
        auxRequest = 0;
        expStall += expGrants;
        total++; if (grants !== expGrants) begin bad++; $display("FAIL burst_grants got=%0d exp=%0d", grants, expGrants); end
        #1;
        total++; if (auxGrant !== 1'b0 || pipeStall !== 1'b0) begin bad++; $display("FAIL burst_exit got g=%b st=%b exp 0 0", auxGrant, pipeStall); end
        total++; if (stallCycles !== 32'(expStall)) begin bad++; $display("FAIL burst_stallCycles got=%0d exp=%0d", stallCycles, expStall); end
        nextCycle(); idleInputs();
    endtask

    task automatic test_reset_mid;
        nextCycle();
        pipeRead = 1; pipeAddress = 32'h100;
        auxRequest = 1; auxWrite = 1; auxAddress = 32'h44; auxWriteData = 32'hCAFEF00D;
        repeat (3) nextCycle();
        #1;
        total++; if (memEnableWrite !== 1'b1 || pipeStall !== 1'b1) begin bad++; $display("FAIL rstmid_pre got we=%b st=%b exp 1 1", memEnableWrite, pipeStall); end
        #1;
        resetMachine = 0;
        #1;
        total++; if (memEnableWrite !== 1'b0 || auxGrant !== 1'b0 || pipeStall !== 1'b0) begin bad++; $display("FAIL rstmid_async got we=%b g=%b st=%b exp 0 0 0", memEnableWrite, auxGrant, pipeStall); end
        total++; if (stallCycles !== 32'd0) begin bad++; $display("FAIL rstmid_stallCycles got=%0d exp=0", stallCycles); end
        nextCycle();
        total++; if (mem[17] !== 32'd0) begin bad++; $display("FAIL rstmid_abandon got=%h exp=0", mem[17]); end
        auxRequest = 0; resetMachine = 1;
        nextCycle();
        auxRequest = 1; auxWrite = 0;
        #1;
        total++; if (auxGrant !== 1'b0 || pipeStall !== 1'b0) begin bad++; $display("FAIL rstmid_state got g=%b st=%b exp 0 0", auxGrant, pipeStall); end
        nextCycle(); idleInputs();
    endtask

    initial begin
        test_reset();
        test_aux_idle();
        test_starvation();
        test_collision();
        test_drop();
        test_burst();
        test_reset_mid();
        repeat (2) nextCycle();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
